// File: rtl/fan_pwm_multi.sv
// fan_pwm_multi: N-channel fan controller. A shared prescaler and PWM period
// counter drive every channel; each channel has its own soft-start duty ramp,
// registered PWM output, tach period measurement and stall detection.
module fan_pwm_multi #(
  parameter int N_CH          = 2,
  parameter int PWM_W         = 8,
  parameter int PRESC_W       = 8,
  parameter int TACH_W        = 16,
  parameter int RAMP_STEP     = 1,
  parameter int STALL_PERIODS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [PRESC_W-1:0]      presc,
  input  logic [N_CH*PWM_W-1:0]   duty_target,
  input  logic [N_CH-1:0]         tach_in,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH*TACH_W-1:0]  tach_count,
  output logic [N_CH-1:0]         tach_valid,
  output logic [N_CH-1:0]         stall,
  output logic [N_CH*PWM_W-1:0]   duty_cur
);

  localparam int MISS_W = $clog2(STALL_PERIODS + 1);

  localparam logic [PWM_W-1:0]   DUTY_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0]   DUTY_ZERO = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0]   STEP      = PWM_W'(RAMP_STEP);
  localparam logic [TACH_W-1:0]  TACH_MAX  = {TACH_W{1'b1}};
  localparam logic [TACH_W-1:0]  TACH_ZERO = {TACH_W{1'b0}};
  localparam logic [TACH_W-1:0]  TACH_ONE  = TACH_W'(1);
  localparam logic [MISS_W-1:0]  MISS_LIM  = MISS_W'(STALL_PERIODS);
  localparam logic [MISS_W-1:0]  MISS_ZERO = {MISS_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

  // ---------------------------------------------------------------------------
  // Shared timebase
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] presc_lat_q, presc_lat_d;
  logic [PRESC_W-1:0] presc_lim_s;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               tick_s;
  logic               ps_s;

  // Prescaler and PWM counter next state; the divider limit is captured at
  // the start of each prescale cycle so a presc change only lands at a wrap.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    presc_lat_d = presc_lat_q;
    pwm_cnt_d   = pwm_cnt_q;
    tick_s      = 1'b0;
    presc_lim_s = (presc_cnt_q == PRESC_ZERO) ? presc : presc_lat_q;
    if (!ena) begin
      presc_cnt_d = PRESC_ZERO;
      presc_lat_d = PRESC_ZERO;
      pwm_cnt_d   = DUTY_ZERO;
    end else begin
      presc_lat_d = presc_lim_s;
      tick_s      = (presc_cnt_q == presc_lim_s);
      if (tick_s) begin
        presc_cnt_d = PRESC_ZERO;
        pwm_cnt_d   = pwm_cnt_q + PWM_W'(1);
      end else begin
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d   = pwm_cnt_q;
      end
    end
    ps_s = tick_s && (pwm_cnt_q == DUTY_MAX);
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q <= PRESC_ZERO;
      presc_lat_q <= PRESC_ZERO;
      pwm_cnt_q   <= DUTY_ZERO;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      presc_lat_q <= presc_lat_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel logic
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [PWM_W-1:0]  tgt_s;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic              rise_s;
    logic [TACH_W-1:0] tcnt_q, tcnt_d;
    logic [TACH_W-1:0] tper_q, tper_d;
    logic              armed_q, armed_d;
    logic              valid_q, valid_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              seen_q, seen_d;
    logic              stall_q, stall_d;

    assign tgt_s  = duty_target[gi*PWM_W +: PWM_W];
    assign rise_s = s2_q & ~s3_q;

    // Soft-start ramp toward the target at each period start, plus PWM compare.
    always_comb begin
      duty_d = duty_q;
      if (!ena) begin
        duty_d = DUTY_ZERO;
      end else if (ps_s) begin
        if (duty_q < tgt_s) begin
          if ((tgt_s - duty_q) > STEP) begin
            duty_d = duty_q + STEP;
          end else begin
            duty_d = tgt_s;
          end
        end else if (duty_q > tgt_s) begin
          if ((duty_q - tgt_s) > STEP) begin
            duty_d = duty_q - STEP;
          end else begin
            duty_d = tgt_s;
          end
        end else begin
          duty_d = duty_q;
        end
      end else begin
        duty_d = duty_q;
      end
      pwm_d = ena & ((duty_q == DUTY_MAX) | (pwm_cnt_q < duty_q));
    end

    // Tach synchronizer and period measurement; the first rise only arms.
    always_comb begin
      s1_d    = tach_in[gi];
      s2_d    = s1_q;
      s3_d    = s2_q;
      tcnt_d  = tcnt_q;
      tper_d  = tper_q;
      armed_d = armed_q;
      valid_d = 1'b0;
      if (!ena) begin
        tcnt_d  = TACH_ZERO;
        armed_d = 1'b0;
        valid_d = 1'b0;
      end else if (rise_s) begin
        tcnt_d  = TACH_ONE;
        armed_d = 1'b1;
        valid_d = armed_q;
        if (armed_q) begin
          tper_d = tcnt_q;
        end else begin
          tper_d = tper_q;
        end
      end else begin
        valid_d = 1'b0;
        if (tcnt_q == TACH_MAX) begin
          tcnt_d = TACH_MAX;
        end else begin
          tcnt_d = tcnt_q + TACH_ONE;
        end
      end
    end

    // Stall detection: count period starts that saw no tach rise; a channel
    // commanded to zero duty is never reported as stalled.
    always_comb begin
      miss_d  = miss_q;
      seen_d  = seen_q;
      stall_d = stall_q;
      if (!ena || (duty_q == DUTY_ZERO)) begin
        miss_d  = MISS_ZERO;
        seen_d  = 1'b0;
        stall_d = 1'b0;
      end else if (ps_s) begin
        if (rise_s || seen_q) begin
          miss_d = MISS_ZERO;
        end else if (miss_q >= MISS_LIM) begin
          miss_d = MISS_LIM;
        end else begin
          miss_d = miss_q + MISS_W'(1);
        end
        seen_d  = 1'b0;
        stall_d = (miss_d >= MISS_LIM);
      end else if (rise_s) begin
        miss_d  = MISS_ZERO;
        seen_d  = 1'b1;
        stall_d = 1'b0;
      end else begin
        miss_d  = miss_q;
        seen_d  = seen_q;
        stall_d = stall_q;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q  <= DUTY_ZERO;
        pwm_q   <= 1'b0;
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        s3_q    <= 1'b0;
        tcnt_q  <= TACH_ZERO;
        tper_q  <= TACH_ZERO;
        armed_q <= 1'b0;
        valid_q <= 1'b0;
        miss_q  <= MISS_ZERO;
        seen_q  <= 1'b0;
        stall_q <= 1'b0;
      end else begin
        duty_q  <= duty_d;
        pwm_q   <= pwm_d;
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        s3_q    <= s3_d;
        tcnt_q  <= tcnt_d;
        tper_q  <= tper_d;
        armed_q <= armed_d;
        valid_q <= valid_d;
        miss_q  <= miss_d;
        seen_q  <= seen_d;
        stall_q <= stall_d;
      end
    end

    assign pwm_out[gi]                     = pwm_q;
    assign tach_count[gi*TACH_W +: TACH_W] = tper_q;
    assign tach_valid[gi]                  = valid_q;
    assign stall[gi]                       = stall_q;
    assign duty_cur[gi*PWM_W +: PWM_W]     = duty_q;
  end

endmodule
